// File: rtl/fan_cmd_if.sv
// fan_cmd_if: command/status bundle between the button/UART front-ends,
// the fan command sequencer and the speed/timer/LED datapaths.
//   btn_pe      local 1-cycle pulses [0]FND [1]SPEED [2]AUTO [3]LED [4]TIMER_STEP
//   bt_pe       Bluetooth 1-cycle pulses, same map plus [5]TIMER_CLR
//   auto_stage  temperature stage used while in auto mode
//   emcy_in/en  emergency level / emergency-stop enable
//   timeout     1-cycle pulse from the timer
//   duty, stage, auto_mode, fsm_state, fnd_sel, timer_step, timer_clr,
//   led_step, drop_cnt: sequencer outputs
// master = stimulus/front-end side, slave = sequencer side.
interface fan_cmd_if;
  logic [4:0] btn_pe;
  logic [5:0] bt_pe;
  logic [1:0] auto_stage;
  logic       emcy_in;
  logic       emcy_en;
  logic       timeout;
  logic [7:0] duty;
  logic [1:0] stage;
  logic       auto_mode;
  logic [1:0] fsm_state;
  logic       fnd_sel;
  logic       timer_step;
  logic       timer_clr;
  logic       led_step;
  logic [7:0] drop_cnt;

  modport master (
    output btn_pe, bt_pe, auto_stage, emcy_in, emcy_en, timeout,
    input  duty, stage, auto_mode, fsm_state, fnd_sel, timer_step, timer_clr,
           led_step, drop_cnt
  );

  modport slave (
    input  btn_pe, bt_pe, auto_stage, emcy_in, emcy_en, timeout,
    output duty, stage, auto_mode, fsm_state, fnd_sel, timer_step, timer_clr,
           led_step, drop_cnt
  );
endinterface

// File: rtl/fan_cmd_sequencer.sv
// fan_cmd_sequencer: merges local and Bluetooth command pulses into one
// command per cycle (local first, 1-deep pending slot for the BT loser),
// runs the OFF/RUN/EMCY_STOP/EMCY_HOLD mode FSM and ramps the PWM duty
// toward the target of the effective stage.
// Ports:
//   clk      system clock
//   reset_p  synchronous active-high reset
//   fan_io   fan_cmd_if.slave (inputs: pulses, auto_stage, emergency,
//            timeout; outputs: duty, stage, mode, state, strobes, drop_cnt)
module fan_cmd_sequencer #(
  parameter int unsigned RAMP_DIV    = 125000,
  parameter int unsigned DUTY_STEP   = 5,
  parameter int unsigned HOLD_CYCLES = 125000000
) (
  input  logic     clk,
  input  logic     reset_p,
  fan_cmd_if.slave fan_io
);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  localparam logic [2:0] C_FND = 3'd0, C_SPEED = 3'd1, C_AUTO = 3'd2,
                         C_LED = 3'd3, C_TSTEP = 3'd4, C_TCLR = 3'd5;

  typedef enum logic [1:0] {S_OFF, S_RUN, S_STOP, S_HOLD} state_t;

  // {valid, index} of the lowest set bit
  function automatic logic [3:0] lowest(input logic [5:0] v);
    lowest = '0;
    for (int i = 5; i >= 0; i--) if (v[i]) lowest = {1'b1, 3'(i)};
  endfunction

  function automatic logic [2:0] ones6(input logic [5:0] v);
    ones6 = '0;
    for (int i = 0; i < 6; i++) ones6 = ones6 + {2'b00, v[i]};
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      stage_q, stage_d;
  logic            auto_q, auto_d, fnd_q, fnd_d;
  logic            tstep_q, tstep_d, tclr_q, tclr_d, led_q, led_d;
  logic [7:0]      duty_q, duty_d, drop_q, drop_d;
  logic [RW-1:0]   ramp_q, ramp_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            pend_vld_q, pend_vld_d;
  logic [2:0]      pend_cmd_q, pend_cmd_d;

  // ---- decode: lowest bit wins, every other set bit is a drop
  logic [3:0] loc_dec, bt_dec;
  logic       loc_vld, bt_vld;
  logic [2:0] loc_cmd, bt_cmd, loc_extra, bt_extra;
  assign loc_dec   = lowest({1'b0, fan_io.btn_pe});
  assign bt_dec    = lowest(fan_io.bt_pe);
  assign loc_vld   = loc_dec[3];
  assign loc_cmd   = loc_dec[2:0];
  assign bt_vld    = bt_dec[3];
  assign bt_cmd    = bt_dec[2:0];
  assign loc_extra = ones6({1'b0, fan_io.btn_pe}) - {2'b00, loc_vld};
  assign bt_extra  = ones6(fan_io.bt_pe) - {2'b00, bt_vld};

  // ---- arbitration
  logic       cmd_vld, lose_drop;
  logic [2:0] cmd;
  always_comb begin
    cmd_vld    = 1'b0;
    cmd        = C_FND;
    lose_drop  = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_cmd_d = pend_cmd_q;
    if (fan_io.timeout) begin
      pend_vld_d = 1'b0;                 // everything this cycle is discarded
    end else if (loc_vld) begin
      cmd_vld = 1'b1;
      cmd     = loc_cmd;
      if (bt_vld) begin
        if (pend_vld_q) lose_drop = 1'b1; // slot keeps the older command
        else begin
          pend_vld_d = 1'b1;
          pend_cmd_d = bt_cmd;
        end
      end
    end else if (pend_vld_q) begin
      cmd_vld    = 1'b1;
      cmd        = pend_cmd_q;
      pend_vld_d = bt_vld;               // new BT command refills the slot
      pend_cmd_d = bt_cmd;
    end else if (bt_vld) begin
      cmd_vld = 1'b1;
      cmd     = bt_cmd;
    end
  end

  // pending content cleared by timeout is not counted as a drop
  logic [3:0] drop_inc;
  logic [8:0] drop_sum;
  assign drop_inc = {1'b0, loc_extra} + {1'b0, bt_extra} + {3'b000, lose_drop}
                  + {3'b000, fan_io.timeout & loc_vld} + {3'b000, fan_io.timeout & bt_vld};
  assign drop_sum = {1'b0, drop_q} + {5'b00000, drop_inc};

  // ---- FSM next state
  logic emcy_act, spd_off;
  assign emcy_act = fan_io.emcy_in & fan_io.emcy_en;
  // manual stage 3 -> 0 switches the fan off from any active state
  assign spd_off  = cmd_vld && (cmd == C_SPEED) && (state_q != S_OFF) && !auto_q
                    && (stage_q == 2'd3);

  always_comb begin
    state_d = state_q;
    if (fan_io.timeout || spd_off) state_d = S_OFF;
    else begin
      case (state_q)
        S_OFF:  if (cmd_vld && (cmd == C_SPEED || cmd == C_AUTO)) state_d = S_RUN;
        S_RUN:  if (emcy_act) state_d = S_STOP;
        S_STOP: if (!emcy_act) state_d = S_HOLD;
        S_HOLD: if (emcy_act) state_d = S_STOP;
                else if (hold_q == HOLD_LAST) state_d = S_RUN;
      endcase
    end
    hold_d = (state_q == S_HOLD && state_d == S_HOLD) ? hold_q + HW'(1) : '0;
  end

  // ---- outputs / datapath next values
  logic [1:0] eff_stage;
  logic [7:0] target;
  logic [8:0] gap;
  assign eff_stage = auto_q ? fan_io.auto_stage : stage_q;
  assign target    = (state_q == S_RUN) ? 8'(eff_stage) * 8'd85 : 8'd0;
  assign gap       = (duty_q < target) ? {1'b0, target} - {1'b0, duty_q}
                                       : {1'b0, duty_q} - {1'b0, target};

  always_comb begin
    stage_d = stage_q;
    auto_d  = auto_q;
    fnd_d   = fnd_q;
    tstep_d = 1'b0;
    tclr_d  = 1'b0;
    led_d   = 1'b0;
    if (fan_io.timeout) begin
      stage_d = 2'd0;
      auto_d  = 1'b0;
    end else if (cmd_vld) begin
      case (cmd)
        C_FND:   fnd_d   = ~fnd_q;
        C_LED:   led_d   = 1'b1;
        C_TCLR:  tclr_d  = 1'b1;
        C_TSTEP: tstep_d = (state_q == S_RUN);
        C_SPEED: if (state_q == S_OFF || auto_q) begin
                   stage_d = 2'd1;
                   auto_d  = 1'b0;
                 end else stage_d = stage_q + 2'd1;
        C_AUTO:  if (state_q == S_OFF || !auto_q) auto_d = 1'b1;
                 else begin
                   auto_d  = 1'b0;
                   stage_d = (fan_io.auto_stage == 2'd0) ? 2'd1 : fan_io.auto_stage;
                 end
        default: ;
      endcase
    end

    duty_d = duty_q;
    ramp_d = ramp_q;
    if (state_d == S_STOP || state_d == S_HOLD) begin
      duty_d = 8'd0;
      ramp_d = '0;
    end else if (duty_q == target) begin
      ramp_d = '0;
    end else if (ramp_q == RAMP_LAST) begin
      ramp_d = '0;
      if (gap <= 9'(DUTY_STEP))  duty_d = target;     // land exactly on target
      else if (duty_q < target)  duty_d = duty_q + 8'(DUTY_STEP);
      else                       duty_d = duty_q - 8'(DUTY_STEP);
    end else begin
      ramp_d = ramp_q + RW'(1);
    end

    drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // ---- registers
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= S_OFF;
      stage_q    <= '0;
      auto_q     <= 1'b0;
      fnd_q      <= 1'b0;
      tstep_q    <= 1'b0;
      tclr_q     <= 1'b0;
      led_q      <= 1'b0;
      duty_q     <= '0;
      drop_q     <= '0;
      ramp_q     <= '0;
      hold_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_cmd_q <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      auto_q     <= auto_d;
      fnd_q      <= fnd_d;
      tstep_q    <= tstep_d;
      tclr_q     <= tclr_d;
      led_q      <= led_d;
      duty_q     <= duty_d;
      drop_q     <= drop_d;
      ramp_q     <= ramp_d;
      hold_q     <= hold_d;
      pend_vld_q <= pend_vld_d;
      pend_cmd_q <= pend_cmd_d;
    end
  end

  assign fan_io.duty       = duty_q;
  assign fan_io.stage      = eff_stage;
  assign fan_io.auto_mode  = auto_q;
  assign fan_io.fsm_state  = state_q;
  assign fan_io.fnd_sel    = fnd_q;
  assign fan_io.timer_step = tstep_q;
  assign fan_io.timer_clr  = tclr_q;
  assign fan_io.led_step   = led_q;
  assign fan_io.drop_cnt   = drop_q;
endmodule
